mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: data memory depth in 32-bit words, a power of 2 in the range 16..4096.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0: extra cycles per memory access, in the range 0..7.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every flop and the RAM are rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have these control inputs, 1 bit each: in_valid (stage holds an instruction), reg_wr_en, mem_rd_en, mem_wr_en, mem_to_reg_wr, load_unsigned, flush.
REQ-006 SHALL have input size, 2 bits: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 SHALL have inputs reg_wr_addr (5 bits), alu_result (32 bits, the address) and mem_wr_data (32 bits).
REQ-008 SHALL have combinational forwarding outputs mem_reg_wr_en, mem_reg_wr_addr[4:0] and mem_alu_result[31:0], which equal the corresponding inputs gated by in_valid.
REQ-009 SHALL have output mem_stall, 1 bit: upstream stages freeze and hold all stage inputs stable while it is high.
REQ-010 SHALL have registered MEM/WB outputs: wb_valid, wb_reg_wr_en, wb_mem_to_reg_wr, wb_reg_wr_addr[4:0], wb_alu_result[31:0], wb_mem_rd_data[31:0], wb_misalign.
REQ-011 SHALL have output stall_cycles, 32 bits (see Configuration).

Function
REQ-012 SHALL form the word index from alu_result[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo the memory size.
REQ-013 SHALL treat an access as misaligned when it is a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-014 SHALL write on a store using byte enables (little-endian):
- byte: lane addr[1:0] receives data[7:0];
- half: lanes addr[1]*2 and addr[1]*2+1 receive data[15:0];
- word: all four lanes receive the full word.
REQ-015 SHALL select the load lane(s) the same way, then sign-extend the result, or zero-extend it when load_unsigned=1.
REQ-016 SHALL run an FSM with states IDLE and WAIT and a 3-bit counter cnt.
REQ-017 SHALL go IDLE->WAIT, with cnt=WAIT_CYCLES-1 and mem_stall=1, when in_valid & (mem_rd_en|mem_wr_en) & !misaligned & WAIT_CYCLES>0.
REQ-018 SHALL, in WAIT, hold mem_stall=1 while cnt!=0 and decrement cnt each cycle.
REQ-019 SHALL, in WAIT with cnt==0, drive mem_stall=0, complete the access on that edge and return to IDLE, giving WAIT_CYCLES+1 cycles per memory op.
REQ-020 SHALL, when WAIT_CYCLES=0, complete every access in the same cycle with mem_stall=0 and no state other than IDLE.
REQ-021 SHALL write the RAM only on the completing edge.
REQ-022 SHALL load the MEM/WB register every cycle:
- while mem_stall=1: a bubble (all wb_* = 0);
- otherwise: wb_valid=in_valid, with the other fields taken from the inputs and the load data.
REQ-023 SHALL, on a misaligned access: perform no RAM access and no stall, force wb_reg_wr_en=0, and set wb_valid=1 and wb_misalign=1 for exactly that one entry.
REQ-024 SHALL treat a non-memory instruction as a one-cycle pass-through with wb_mem_rd_data=0.
REQ-025 SHALL, when flush=1: load a bubble at the next edge, force the FSM to IDLE with cnt=0, and suppress any pending write; flush also wins over a completion in the same cycle.
REQ-026 SHALL ignore mem_wr_en and mem_rd_en whenever in_valid=0.

Reset
REQ-027 SHALL, on reset assertion, immediately and asynchronously force: all wb_* to 0, the FSM to IDLE, cnt=0, mem_stall=0 and stall_cycles=0.
REQ-028 SHALL not clear RAM contents on reset; a reset during WAIT abandons the access and performs no write.

Configuration
REQ-029 SHALL, when MEM_STALL_CNT_EN is defined, increment stall_cycles by 1 every cycle mem_stall=1, saturating at 0xFFFFFFFF, with reset clearing it to 0.
REQ-030 SHALL, when MEM_STALL_CNT_EN is undefined, tie stall_cycles to 0 with no counter logic.

Verification
REQ-031 SHALL cover a store then load with WAIT_CYCLES=0, in two back-to-back entries:
- entry 1: store word 0xDEADBEEF to address 0x40;
- entry 2: load word from 0x40;
- response: wb_mem_rd_data=0xDEADBEEF, mem_stall never high.
REQ-032 SHALL cover byte/half extension after storing word 0x80FF7F01 at 0x10:
- load byte signed from 0x13 -> 0xFFFFFF80;
- load byte unsigned from 0x13 -> 0x00000080;
- load half signed from 0x10 -> 0x00007F01.
REQ-033 SHALL cover a waited access with WAIT_CYCLES=2: load word -> mem_stall high for exactly 2 cycles, 2 bubbles, then one valid entry; stall_cycles=2 with the macro defined, 0 without.
REQ-034 SHALL cover a misaligned store: half store to 0x21 -> RAM unchanged, wb_misalign=1 for 1 cycle, wb_reg_wr_en=0.
REQ-035 SHALL cover flush during wait with WAIT_CYCLES=3: store 0x12345678 to 0x8, with flush asserted on the second stall cycle -> FSM returns to IDLE and a later load from 0x8 returns the old value.
REQ-036 SHALL cover reset mid-wait and address wrap with DEPTH_WORDS=16:
- reset asserted asynchronously in WAIT -> all wb_*=0 and mem_stall=0 immediately;
- afterwards, store to 0x40, then load from 0x00 -> the same data.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with a byte-addressable data RAM,
// optional wait-state FSM (WAIT_CYCLES) and a registered MEM/WB interface.
// Optional feature: define MEM_STALL_CNT_EN to build the saturating
// stall-cycle counter behind stall_cycles; otherwise stall_cycles is 0.
module mem_access_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        reg_wr_en,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic        mem_to_reg_wr,
    input  logic        load_unsigned,
    input  logic        flush,
    input  logic [1:0]  size,
    input  logic [4:0]  reg_wr_addr,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_wr_data,
    output logic        mem_reg_wr_en,
    output logic [4:0]  mem_reg_wr_addr,
    output logic [31:0] mem_alu_result,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_reg_wr_en,
    output logic        wb_mem_to_reg_wr,
    output logic [4:0]  wb_reg_wr_addr,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_mem_rd_data,
    output logic        wb_misalign,
    output logic [31:0] stall_cycles
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
    localparam logic       HAS_WAIT = (WAIT_CYCLES > 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx_s;
    logic          is_byte_s, is_half_s;
    logic          mem_op_s, misalign_s, req_s;
    logic          stall_s, complete_s, we_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;
    logic [31:0]   rd_word_s, load_s;
    logic [7:0]    byte_sel_s;
    logic [15:0]   half_sel_s;

    logic          wb_valid_d, wb_reg_wr_en_d, wb_mem_to_reg_wr_d, wb_misalign_d;
    logic [4:0]    wb_reg_wr_addr_d;
    logic [31:0]   wb_alu_result_d, wb_mem_rd_data_d;
    logic          wb_valid_q, wb_reg_wr_en_q, wb_mem_to_reg_wr_q, wb_misalign_q;
    logic [4:0]    wb_reg_wr_addr_q;
    logic [31:0]   wb_alu_result_q, wb_mem_rd_data_q;

    // Address decode: word index wraps modulo the RAM size; upper bits ignored.
    assign idx_s      = alu_result[AW+1:2];
    assign is_byte_s  = (size == 2'b00);
    assign is_half_s  = (size == 2'b01);
    assign mem_op_s   = in_valid & (mem_rd_en | mem_wr_en);
    assign misalign_s = mem_op_s & ((is_half_s & alu_result[0]) |
                        (~is_byte_s & ~is_half_s & (alu_result[1:0] != 2'b00)));
    assign req_s      = mem_op_s & ~misalign_s;

    // Forwarding path to the hazard/bypass logic, killed when the stage is empty.
    assign mem_reg_wr_en   = in_valid & reg_wr_en;
    assign mem_reg_wr_addr = in_valid ? reg_wr_addr : 5'd0;
    assign mem_alu_result  = in_valid ? alu_result : 32'd0;

    // Wait-state FSM: next state, counter and stall/complete decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_s    = 1'b0;
        complete_s = 1'b0;
        if (flush) begin
            // Flush kills the instruction, including one completing this cycle.
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        if (HAS_WAIT) begin
                            state_d = ST_WAIT;
                            cnt_d   = CNT_INIT;
                            stall_s = 1'b1;
                        end else begin
                            complete_s = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!req_s) begin
                        // Upstream dropped the request: abandon without writing.
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end else if (cnt_q != 3'd0) begin
                        cnt_d   = cnt_q - 3'd1;
                        stall_s = 1'b1;
                    end else begin
                        complete_s = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // Reset overrides the stall immediately, independent of the clock.
    assign mem_stall = stall_s & ~reset;
    assign we_s      = complete_s & mem_wr_en & ~reset;

    // Store lane selection: replicate the data and enable the addressed lanes.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = mem_wr_data;
        case (size)
            2'b00: begin
                be_s    = 4'b0001 << alu_result[1:0];
                wdata_s = {4{mem_wr_data[7:0]}};
            end
            2'b01: begin
                be_s    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{mem_wr_data[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = mem_wr_data;
            end
        endcase
    end

    // Load lane selection followed by sign or zero extension.
    always_comb begin
        rd_word_s  = mem_q[idx_s];
        byte_sel_s = 8'd0;
        half_sel_s = alu_result[1] ? rd_word_s[31:16] : rd_word_s[15:0];
        case (alu_result[1:0])
            2'b00:   byte_sel_s = rd_word_s[7:0];
            2'b01:   byte_sel_s = rd_word_s[15:8];
            2'b10:   byte_sel_s = rd_word_s[23:16];
            default: byte_sel_s = rd_word_s[31:24];
        endcase
        case (size)
            2'b00:   load_s = load_unsigned ? {24'd0, byte_sel_s} : {{24{byte_sel_s[7]}}, byte_sel_s};
            2'b01:   load_s = load_unsigned ? {16'd0, half_sel_s} : {{16{half_sel_s[15]}}, half_sel_s};
            default: load_s = rd_word_s;
        endcase
    end

    // MEM/WB next value: bubble on stall, flush or empty stage.
    always_comb begin
        wb_valid_d         = 1'b0;
        wb_reg_wr_en_d     = 1'b0;
        wb_mem_to_reg_wr_d = 1'b0;
        wb_reg_wr_addr_d   = 5'd0;
        wb_alu_result_d    = 32'd0;
        wb_mem_rd_data_d   = 32'd0;
        wb_misalign_d      = 1'b0;
        if (flush || stall_s || !in_valid) begin
            wb_valid_d = 1'b0;
        end else begin
            wb_valid_d         = 1'b1;
            wb_reg_wr_en_d     = reg_wr_en & ~misalign_s;
            wb_mem_to_reg_wr_d = mem_to_reg_wr;
            wb_reg_wr_addr_d   = reg_wr_addr;
            wb_alu_result_d    = alu_result;
            wb_mem_rd_data_d   = (req_s & mem_rd_en) ? load_s : 32'd0;
            wb_misalign_d      = misalign_s;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q         <= 1'b0;
            wb_reg_wr_en_q     <= 1'b0;
            wb_mem_to_reg_wr_q <= 1'b0;
            wb_reg_wr_addr_q   <= 5'd0;
            wb_alu_result_q    <= 32'd0;
            wb_mem_rd_data_q   <= 32'd0;
            wb_misalign_q      <= 1'b0;
        end else begin
            wb_valid_q         <= wb_valid_d;
            wb_reg_wr_en_q     <= wb_reg_wr_en_d;
            wb_mem_to_reg_wr_q <= wb_mem_to_reg_wr_d;
            wb_reg_wr_addr_q   <= wb_reg_wr_addr_d;
            wb_alu_result_q    <= wb_alu_result_d;
            wb_mem_rd_data_q   <= wb_mem_rd_data_d;
            wb_misalign_q      <= wb_misalign_d;
        end
    end

    // Data RAM write port: contents survive reset, lanes written on completion only.
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int l = 0; l < 4; l++) begin
                if (be_s[l]) begin
                    mem_q[idx_s][8*l +: 8] <= wdata_s[8*l +: 8];
                end
            end
        end
    end

    assign wb_valid         = wb_valid_q;
    assign wb_reg_wr_en     = wb_reg_wr_en_q;
    assign wb_mem_to_reg_wr = wb_mem_to_reg_wr_q;
    assign wb_reg_wr_addr   = wb_reg_wr_addr_q;
    assign wb_alu_result    = wb_alu_result_q;
    assign wb_mem_rd_data   = wb_mem_rd_data_q;
    assign wb_misalign      = wb_misalign_q;

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
